// File: rtl/apb_regmem_pkg.sv
// rtl/apb_regmem_pkg.sv - shared FSM type, address offsets and CTRL field layout for apb_regmem_slave
package apb_regmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Register addresses counted down from the top of the address space
  localparam int CTRL_ADDR_OFS = 1;
  localparam int STAT_ADDR_OFS = 2;

  localparam int WAIT_CFG_W   = 4;
  localparam int WAIT_CFG_LSB = 0;
  localparam int WP_BIT       = 8;

endpackage

// File: rtl/apb_strb_merge.sv
// rtl/apb_strb_merge.sv - byte-lane merge of write data into an existing word under a strobe mask
module apb_strb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_word,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   new_word
);

  always_comb begin
    new_word = old_word;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (strb[b]) new_word[b*8 +: 8] = wdata[b*8 +: 8];
    end
  end

endmodule

// File: rtl/apb_regmem_slave.sv
// rtl/apb_regmem_slave.sv - APB4 RAM + CTRL slave with programmable waits; APB_REGMEM_STATS_EN adds STAT counters
module apb_regmem_slave
  import apb_regmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 192,
  parameter int WAIT_STATES = 3
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] RAM_END   = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = {ADDR_WIDTH{1'b1}} - ADDR_WIDTH'(CTRL_ADDR_OFS - 1);
  localparam logic [WAIT_CFG_W-1:0] CNT_ONE   = WAIT_CFG_W'(1);

  state_t                  state_q, state_d;
  logic [WAIT_CFG_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [WAIT_CFG_W-1:0]   wait_cfg;
  logic                    wp;
  logic [DATA_WIDTH-1:0]   ram [DEPTH];

  logic                    accept, fire, commit, err;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic                    cur_write, is_ram, is_ctrl, is_stat;
  logic [IDX_W-1:0]        ram_idx;
  logic [DATA_WIDTH-1:0]   ram_word, ram_new, ctrl_word, ctrl_new, stat_word, rdata;
  logic                    unused_ctrl_bits;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && PENABLE) begin
          accept = 1'b1;
          // The access cycle itself is the first wait cycle, so W=0 answers on the next edge
          if (wait_cfg == '0) begin
            state_d = RESP;
            fire    = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = wait_cfg - CNT_ONE;
          end
        end
      end
      WAIT: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = RESP;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_addr  = (state_q == IDLE) ? PADDR : addr_q;
    cur_write = (state_q == IDLE) ? PWRITE : write_q;
    is_ram    = cur_addr < RAM_END;
    is_ctrl   = cur_addr == CTRL_ADDR;
    ram_idx   = is_ram ? cur_addr[IDX_W-1:0] : '0;
    err       = !(is_ram || is_ctrl || is_stat) || (cur_write && is_ram && wp) ||
                (!cur_write && (PSTRB != '0));
    commit    = fire && cur_write && !err;
    ctrl_word = '0;
    ctrl_word[WAIT_CFG_LSB +: WAIT_CFG_W] = wait_cfg;
    ctrl_word[WP_BIT] = wp;
    rdata = '0;
    if (!err && !cur_write) begin
      if (is_ram)       rdata = ram_word;
      else if (is_ctrl) rdata = ctrl_word;
      else              rdata = stat_word;
    end
  end

  assign ram_word         = ram[ram_idx];
  assign unused_ctrl_bits = ^ctrl_new;

  apb_strb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_ram_merge (
    .old_word (ram_word),
    .wdata    (PWDATA),
    .strb     (PSTRB),
    .new_word (ram_new)
  );

  apb_strb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_ctrl_merge (
    .old_word (ctrl_word),
    .wdata    (PWDATA),
    .strb     (PSTRB),
    .new_word (ctrl_new)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wait_cfg <= WAIT_CFG_W'(WAIT_STATES);
      wp       <= 1'b0;
      PREADY   <= 1'b0;
      PSLVERR  <= 1'b0;
      PRDATA   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= PADDR;
        write_q <= PWRITE;
      end
      PREADY  <= fire;
      PSLVERR <= fire && err;
      PRDATA  <= fire ? rdata : '0;
      if (commit && is_ctrl) begin
        wait_cfg <= ctrl_new[WAIT_CFG_LSB +: WAIT_CFG_W];
        wp       <= ctrl_new[WP_BIT];
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    end else if (commit && is_ram) begin
      ram[ram_idx] <= ram_new;
    end
  end

`ifdef APB_REGMEM_STATS_EN
  localparam int HALF = DATA_WIDTH / 2;
  localparam logic [ADDR_WIDTH-1:0] STAT_ADDR = {ADDR_WIDTH{1'b1}} - ADDR_WIDTH'(STAT_ADDR_OFS - 1);

  logic [HALF-1:0] ok_cnt, err_cnt;

  assign is_stat   = cur_addr == STAT_ADDR;
  assign stat_word = {err_cnt, ok_cnt};

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ok_cnt  <= '0;
      err_cnt <= '0;
    end else if (fire) begin
      // A STAT write clears the counters and is itself left uncounted
      if (cur_write && is_stat) begin
        ok_cnt  <= '0;
        err_cnt <= '0;
      end else if (err) begin
        if (err_cnt != '1) err_cnt <= err_cnt + HALF'(1);
      end else begin
        if (ok_cnt != '1) ok_cnt <= ok_cnt + HALF'(1);
      end
    end
  end
`else
  assign is_stat   = 1'b0;
  assign stat_word = '0;
`endif

endmodule

// File: tb/tb_apb_regmem_slave.sv
// tb/tb_apb_regmem_slave.sv - scoreboard bench for apb_regmem_slave; honours APB_REGMEM_STATS_EN
module tb_apb_regmem_slave;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 192;
  localparam int WS    = 3;
`ifdef APB_REGMEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          PCLK = 1'b0;
  logic          PRESET, PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [3:0]    PSTRB;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;

  apb_regmem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PSTRB(PSTRB), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  typedef struct {
    bit          is_read;
    logic [31:0] rdata;
    bit          err;
    int          rdy_cyc;
    logic [7:0]  addr;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state
  logic [31:0] m_ram [DEPTH];
  int          m_wait;
  bit          m_wp;
  int          m_ok, m_errc;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = w[b*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_ram[i] = '0;
    m_wait = WS;
    m_wp   = 1'b0;
    m_ok   = 0;
    m_errc = 0;
    sb.delete();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
    end
  endtask

  always @(negedge PCLK) begin
    if (PREADY) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pready at cycle %0d: got PREADY=1 want 0", cyc);
      end else begin
        me = sb.pop_front();
        check($sformatf("latency addr=%0d", me.addr), cyc, me.rdy_cyc);
        check($sformatf("pslverr addr=%0d", me.addr), {31'b0, PSLVERR}, {31'b0, me.err});
        if (me.is_read) check($sformatf("prdata addr=%0d", me.addr), PRDATA, me.rdata);
      end
    end else if (PSLVERR) begin
      miscompares++;
      $display("FAIL pslverr_without_pready at cycle %0d: got 1 want 0", cyc);
    end
  end

  task automatic apb_xfer(input bit wr, input logic [7:0] addr, input logic [3:0] strb,
                          input logic [31:0] wdata);
    exp_t        e;
    bit          is_ram, is_ctrl, is_stat, mapped, err, got;
    logic [31:0] cur, merged;
    int          a0;
    is_ram  = addr < DEPTH;
    is_ctrl = addr == 8'hFF;
    is_stat = STATS && addr == 8'hFE;
    mapped  = is_ram || is_ctrl || is_stat;
    err     = !mapped || (wr && is_ram && m_wp) || (!wr && strb != 4'h0);
    if (is_ram)       cur = m_ram[addr];
    else if (is_ctrl) cur = {23'b0, m_wp, 4'b0, 4'(m_wait)};
    else              cur = {m_errc[15:0], m_ok[15:0]};
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PSTRB = strb; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    a0 = cyc;
    e.is_read = !wr;
    e.err     = err;
    e.rdata   = (err || wr) ? 32'h0 : cur;
    e.rdy_cyc = a0 + m_wait + 1;
    e.addr    = addr;
    sb.push_back(e);
    if (wr && !err) begin
      merged = merge(cur, wdata, strb);
      if (is_ram) m_ram[addr] = merged;
      else if (is_ctrl) begin
        m_wait = int'(merged[3:0]);
        m_wp   = merged[8];
      end else begin
        m_ok   = 0;
        m_errc = 0;
      end
    end
    if (!(wr && is_stat)) begin
      if (err) m_errc = (m_errc < 65535) ? m_errc + 1 : m_errc;
      else     m_ok   = (m_ok   < 65535) ? m_ok + 1   : m_ok;
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge PCLK);
      got = PREADY;
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout addr=%0d: got no PREADY want PREADY within 40 cycles", addr);
      sb.delete();
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge PCLK); #1;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); @(posedge PCLK); #1;
    PRESET = 1'b0;
    model_reset();
  endtask

  // Write that is cut short either by reset or by PSEL falling during WAIT
  task automatic aborted_write(input bit by_reset, input logic [7:0] addr, input logic [31:0] wdata);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PSTRB = 4'hF; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    if (by_reset) begin
      PRESET = 1'b1;
      @(posedge PCLK); #1;
      PRESET = 1'b0;
      model_reset();
    end
    repeat (20) @(posedge PCLK);
    #1;
    check("abort_pready", {31'b0, PREADY}, 32'h0);
  endtask

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PSTRB = '0; PWDATA = '0;
    model_reset();
    repeat (3) @(posedge PCLK);
    #1;
    check("reset_pready", {31'b0, PREADY}, 32'h0);
    check("reset_pslverr", {31'b0, PSLVERR}, 32'h0);
    check("reset_prdata", PRDATA, 32'h0);
    PRESET = 1'b0;

    apb_xfer(1'b0, 8'd5, 4'h0, 32'h0);
    apb_xfer(1'b0, 8'hFF, 4'h0, 32'h0);

    apb_xfer(1'b1, 8'd10, 4'hF, 32'hAABBCCDD);
    apb_xfer(1'b1, 8'd10, 4'h5, 32'h11223344);
    apb_xfer(1'b0, 8'd10, 4'h0, 32'h0);

    apb_xfer(1'b1, 8'hFF, 4'hF, 32'h0);
    apb_xfer(1'b0, 8'd10, 4'h0, 32'h0);
    apb_xfer(1'b1, 8'hFF, 4'hF, 32'hF);
    apb_xfer(1'b0, 8'd10, 4'h0, 32'h0);
    apb_xfer(1'b1, 8'hFF, 4'h0, 32'h0);
    apb_xfer(1'b1, 8'hFF, 4'h1, 32'h2);

    apb_xfer(1'b0, 8'd200, 4'h0, 32'h0);
    apb_xfer(1'b0, 8'd10, 4'h1, 32'h0);
    apb_xfer(1'b1, 8'hFF, 4'hF, 32'h103);
    apb_xfer(1'b1, 8'd1, 4'hF, 32'h55);
    apb_xfer(1'b0, 8'd1, 4'h0, 32'h0);
    apb_xfer(1'b0, 8'hFF, 4'h0, 32'h0);
    apb_xfer(1'b1, 8'hFF, 4'hF, 32'h003);
    apb_xfer(1'b1, 8'd1, 4'hF, 32'h55);
    apb_xfer(1'b0, 8'd1, 4'h0, 32'h0);
    apb_xfer(1'b0, 8'd191, 4'h0, 32'h0);
    apb_xfer(1'b0, 8'd192, 4'h0, 32'h0);
    apb_xfer(1'b1, 8'd192, 4'hF, 32'h1);

    do_reset();
    aborted_write(1'b1, 8'd2, 32'h77);
    apb_xfer(1'b0, 8'd2, 4'h0, 32'h0);
    aborted_write(1'b0, 8'd3, 32'h99);
    apb_xfer(1'b0, 8'd3, 4'h0, 32'h0);

    do_reset();
    apb_xfer(1'b1, 8'd0, 4'hF, 32'h12345678);
    apb_xfer(1'b0, 8'd0, 4'h0, 32'h0);
    apb_xfer(1'b0, 8'hFF, 4'h0, 32'h0);
    apb_xfer(1'b0, 8'd200, 4'h0, 32'h0);
    apb_xfer(1'b0, 8'd0, 4'h1, 32'h0);
    apb_xfer(1'b0, 8'hFE, 4'h0, 32'h0);
    apb_xfer(1'b1, 8'hFE, 4'h0, 32'hFFFFFFFF);
    apb_xfer(1'b0, 8'hFE, 4'h0, 32'h0);

    for (int n = 0; n < 300; n++) begin
      int          kind;
      bit          wr;
      logic [7:0]  a;
      logic [3:0]  s;
      logic [31:0] d;
      kind = $urandom_range(0, 9);
      wr   = 1'($urandom_range(0, 1));
      d    = $urandom;
      s    = 4'($urandom);
      if (!wr && $urandom_range(0, 4) != 0) s = 4'h0;
      case (kind)
        6:       a = 8'hFF;
        7:       a = 8'hFE;
        8:       a = 8'($urandom_range(DEPTH, 253));
        9: begin a = 8'hFF; wr = 1'b1; s = 4'h3; d = 32'($urandom_range(0, 4)); end
        default: a = 8'($urandom_range(0, DEPTH - 1));
      endcase
      apb_xfer(wr, a, s, d);
    end

    repeat (5) @(posedge PCLK);
    #1;
    check("scoreboard_drained", sb.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
